// File: rtl/fixed_point_div_pkg.sv
// Shared fixed-point geometry, the divider state encoding and the divider iteration count.
package fixed_point_div_pkg;

  localparam int unsigned FIXED_W                  = 32;
  localparam int unsigned FIXED_FRACTION_W         = 16;
  localparam int unsigned FIXED_DIV_BITS_PER_CYCLE = 1;
  localparam int unsigned FIXED_DIV_ITERS          =
    (FIXED_W + FIXED_FRACTION_W) / FIXED_DIV_BITS_PER_CYCLE;

  typedef logic signed [FIXED_W-1:0] fixed_point_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module fixed_point_div_step
  import fixed_point_div_pkg::*;
(
  input  logic [FIXED_W:0]   i_rem,
  input  logic [FIXED_W-1:0] i_divisor,
  input  logic               i_bit,
  output logic [FIXED_W:0]   o_rem,
  output logic               o_q
);

  logic [FIXED_W+1:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= (FIXED_W+2)'(i_divisor));
  // The remainder stays below the divisor, so the top bit never survives a step.
  assign o_rem   = (FIXED_W+1)'(o_q ? (w_shift - (FIXED_W+2)'(i_divisor)) : w_shift);

endmodule

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider (restoring, BITS_PER_CYCLE quotient bits per cycle)
// with valid/ready handshakes on both operand and result sides.
module fixed_point_div
  import fixed_point_div_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = FIXED_DIV_BITS_PER_CYCLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  fixed_point_t op1,
  input  fixed_point_t op2,
  output logic         out_valid,
  input  logic         out_ready,
  output fixed_point_t result,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned QW    = FIXED_W + FIXED_FRACTION_W;
  localparam int unsigned ITERS = QW / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  div_state_t           r_state;
  div_state_t           w_next_state;
  logic                 w_in_ready;
  logic                 w_out_valid;

  logic                 r_sign;
  logic [FIXED_W-1:0]   r_divisor;
  logic [QW-1:0]        r_dividend;
  logic [FIXED_W:0]     r_rem;
  logic [QW-1:0]        r_quot;
  logic [CNT_W-1:0]     r_cnt;
  fixed_point_t         r_result;
  logic                 r_overflow;
  logic                 r_dbz;

  logic [FIXED_W-1:0]   w_op1_abs;
  logic [FIXED_W-1:0]   w_op2_abs;
  logic                 w_op2_zero;
  logic                 w_last;
  logic [FIXED_W:0]     w_rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qbits;
  logic [QW-1:0]        w_quot_next;
  fixed_point_t         w_res_next;
  logic                 w_ovf_next;

  // Magnitudes as unsigned values; the most negative operand maps to 2^(W-1).
  assign w_op1_abs  = op1[FIXED_W-1] ? FIXED_W'(-op1) : FIXED_W'(op1);
  assign w_op2_abs  = op2[FIXED_W-1] ? FIXED_W'(-op2) : FIXED_W'(op2);
  assign w_op2_zero = (op2 == '0);
  assign w_last     = (r_cnt == '0);

  assign w_rem_chain[0] = r_rem;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    fixed_point_div_step u_step (
      .i_rem     (w_rem_chain[g]),
      .i_divisor (r_divisor),
      .i_bit     (r_dividend[QW-1-g]),
      .o_rem     (w_rem_chain[g+1]),
      .o_q       (w_qbits[BITS_PER_CYCLE-1-g])
    );
  end

  assign w_quot_next = QW'({r_quot, w_qbits});
  assign w_res_next  = FIXED_W'(r_sign ? -w_quot_next : w_quot_next);
  // A negative quotient may reach exactly 2^(W-1) without overflowing.
  assign w_ovf_next  = (|w_quot_next[QW-1:FIXED_W]) ||
                       (w_quot_next[FIXED_W-1] && (!r_sign || (|w_quot_next[FIXED_W-2:0])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = w_op2_zero ? DONE : CALC;
      CALC:    if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_op2_zero) begin
              r_result   <= '0;
              r_overflow <= 1'b0;
              r_dbz      <= 1'b1;
            end else begin
              r_sign     <= op1[FIXED_W-1] ^ op2[FIXED_W-1];
              r_divisor  <= w_op2_abs;
              r_dividend <= {w_op1_abs, {FIXED_FRACTION_W{1'b0}}};
              r_rem      <= '0;
              r_quot     <= '0;
              r_cnt      <= CNT_W'(ITERS - 1);
              r_overflow <= 1'b0;
              r_dbz      <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem      <= w_rem_chain[BITS_PER_CYCLE];
          r_quot     <= w_quot_next;
          r_dividend <= r_dividend << BITS_PER_CYCLE;
          r_cnt      <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_result   <= w_res_next;
            r_overflow <= w_ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign result      = r_result;
  assign overflow    = r_overflow;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_fixed_point_div.sv
// Bench for fixed_point_div: directed corner cases plus random operands against an integer model.
module tb_fixed_point_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  fixed_point_div dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1         (op1),
    .op2         (op2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Q16.16 quotient by plain 64-bit integer arithmetic, truncated toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ovf, output logic dbz);
    longint ua, ub, q;
    bit     s;
    if (b == 32'd0) begin
      res = 32'd0; ovf = 1'b0; dbz = 1'b1;
      return;
    end
    ua = longint'($signed(a));
    ub = longint'($signed(b));
    if (ua < 0) ua = -ua;
    if (ub < 0) ub = -ub;
    q  = (ua * 65536) / ub;
    s  = a[31] ^ b[31];
    res = s ? 32'(-q) : 32'(q);
    ovf = s ? (q > 64'sd2147483648) : (q >= 64'sd2147483648);
    dbz = 1'b0;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns the same way, idle again.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input logic ed, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 49;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_overflow"}, 64'(overflow), 64'(eo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op1 = $urandom;
      op2 = $urandom;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_result"}, 64'({result, overflow, div_by_zero}), 64'({er, eo, ed}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        eo, ed;
    int          stale;

    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'({result, overflow, div_by_zero}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("basic", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 0);
    run_op("neg_trunc", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 0);
    run_op("div_zero", 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 0);
    run_op("ovf_pos", 32'h4000_0000, 32'h0000_8000, 32'h8000_0000, 1'b1, 1'b0, 0);
    run_op("ovf_neg_edge", 32'hC000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("min_by_one", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("backpressure", 32'h0007_8000, 32'hFFFE_0000, 32'hFFFC_4000, 1'b0, 1'b0, 5);
    run_op("after_bp", 32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 1'b0, 1'b0, 0);

    // Abort a division partway through CALC with an asynchronous reset.
    in_valid = 1'b1;
    op1 = 32'h0006_0000;
    op2 = 32'h0002_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check("abort_no_stale", 64'(stale), 64'd0);
    run_op("after_abort", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 32'h00FF_FFFF));
      if ($urandom_range(0, 1) == 0) ra = -ra;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rb = 32'd0;
      else if (sel < 5)  rb = 32'($urandom_range(1, 32'h0003_FFFF));
      else               rb = $urandom;
      if ($urandom_range(0, 1) == 0) rb = -rb;
      model(ra, rb, er, eo, ed);
      run_op("random", ra, rb, er, eo, ed, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_div.md
Name: fixed_point_div

Overview:
Sequential signed fixed-point divider; the inverse operation of the team's combinational fixed-point multiplier. It computes op1 / op2 on `fixed_point::fixed_point_t` operands, one quotient bit group per cycle, using a restoring algorithm. It sits beside the multiplier in the fixed_point library. Geometry code (perspective divide, slope setup) drives it through valid/ready handshakes.

Parameters:
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; must divide (`FIXED_W + `FIXED_FRACTION_W`).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  divider can accept operands
op1  input  fixed_point_t (`FIXED_W)  dividend
op2  input  fixed_point_t (`FIXED_W)  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  fixed_point_t (`FIXED_W)  quotient
overflow  output  1  quotient not representable
div_by_zero  output  1  op2 was zero

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1, out_valid=0, result=0, overflow=0, div_by_zero=0. Reset takes effect immediately and aborts any division in flight; no result is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid is high, operands are captured on the clock edge.
  - If op2==0: go to DONE with result=0, div_by_zero=1, overflow=0.
  - Otherwise: latch sign = sign(op1) XOR sign(op2); latch |op1| and |op2| as unsigned `FIXED_W values (|0x8000_0000| = 0x8000_0000); clear the quotient and the remainder; go to CALC.
- CALC: N = (`FIXED_W + `FIXED_FRACTION_W) / BITS_PER_CYCLE cycles.
  - Effective dividend is {|op1|, `FIXED_FRACTION_W zeros}, consumed MSB first.
  - Remainder register is `FIXED_W+1 bits.
  - Per bit: shift the next dividend bit into the remainder; if remainder >= |op2|, subtract and set the quotient bit to 1, else set it to 0.
  - Iteration counter down-counts. After the final iteration, go to DONE.
- Arithmetic:
  - Q = floor(|op1|·2^F / |op2|), held as `FIXED_W+F bits.
  - Rounding is truncation toward zero for both signs.
  - result = low `FIXED_W bits of (sign ? −Q : Q).
  - overflow = (!sign && Q >= 2^(W−1)) || (sign && Q > 2^(W−1)). An exact result of −2^(W−1) does not overflow.
  - result is still the truncated value when overflow=1.
- DONE: out_valid=1. result, overflow and div_by_zero are registered and held stable while out_valid=1 and out_ready=0.
  - When out_ready is high on an edge: go to IDLE and drop out_valid.
  - in_ready=0 in DONE; the next operand set can be accepted no earlier than the cycle after the output handshake.
- Latency, from accept edge to out_valid: N+1 edges for normal operands; 1 edge for divide-by-zero.
- in_ready=0 in CALC and DONE. Operand changes while in_ready=0 are ignored.
- Back-to-back throughput: one result per N+2 cycles when out_ready is tied high.

Decomposition:
- fixed_point package:
  - add `FIXED_DIV_ITERS` = (`FIXED_W + `FIXED_FRACTION_W`) / BITS_PER_CYCLE;
  - add a `div_state_t` enum {IDLE, CALC, DONE};
  - reuse `fixed_point_t`.
- Sub-module: fixed_point_div_step, a combinational single restoring step (remainder in, divisor, next dividend bit → remainder out, quotient bit). It is instantiated BITS_PER_CYCLE times in a chain inside CALC.
- The abs/negate logic stays inline.

Test Plan:
(Bench configuration: `FIXED_W=32, `FIXED_FRACTION_W=16, BITS_PER_CYCLE=1, so N=48.)
1. Basic divide: op1=0x0006_0000 (6.0), op2=0x0002_0000 (2.0) → result=0x0003_0000, overflow=0, div_by_zero=0; out_valid asserts exactly 49 edges after accept.
2. Negative, truncation toward zero: op1=0xFFFF_0000 (−1.0), op2=0x0003_0000 → result=0xFFFF_AAAB (−0x5555), overflow=0.
3. Divide by zero: op1=0x0001_0000, op2=0 → div_by_zero=1, result=0, overflow=0; out_valid one edge after accept.
4. Overflow boundary:
   - 0x4000_0000 / 0x0000_8000 → result=0x8000_0000, overflow=1.
   - 0xC000_0000 / 0x0000_8000 → result=0x8000_0000, overflow=0.
   - 0x8000_0000 / 0x0001_0000 → result=0x8000_0000, overflow=0.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid → result and flags stable, in_ready=0, new in_valid ignored. Raise out_ready → next cycle in_ready=1 and the next operands are accepted.
6. Reset mid-operation: assert rst asynchronously at CALC cycle 10 → out_valid=0 and in_ready=1 immediately. After release, 6.0/2.0 again yields 0x0003_0000 with no stale output.
